video_pixel_out: RTL
====================

# video_pixel_out

Downstream stage of `video_sync_gen`: fetches a pixel stream from the frame-buffer reader through a prefetch FIFO and aligns it with the registered sync-gen outputs. Produces the final DE/HS/VS/RGB video bus, with one aligned `clk_en` cycle of latency. Detects stream underflow and frame misalignment, then resynchronises on the next frame start.

## Interface
Parameters:
- `DW`, 24: pixel data width (RGB888).
- `AW`, 4: FIFO address width; depth is 2^AW words.
- `UNDER_COLOR`, 24'hff00ff: pixel driven on underflow or sync error.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `clk_en`, in, 1: pixel clock enable (same as sync gen).
- `en`, in, 1: block enable. Low means flush FIFO, go to WAIT_SOF, outputs blank.
- `active`, in, 1: from sync gen.
- `blank`, in, 1: from sync gen.
- `a_start`, in, 1: from sync gen.
- `h_sync`, in, 1: from sync gen (already polarity-applied).
- `v_sync`, in, 1: from sync gen (already polarity-applied).
- `pix_dat`, in, DW: stream pixel.
- `pix_sof`, in, 1: stream word is first pixel of a frame.
- `pix_vld`, in, 1: stream valid.
- `pix_rdy`, out, 1: stream ready.
- `vid_dat`, out, DW: output pixel.
- `vid_de`, out, 1: output data enable.
- `vid_hs`, out, 1: output horizontal sync.
- `vid_vs`, out, 1: output vertical sync.
- `underflow`, out, 1: sticky; set on any underflow or sync error.
- `clr`, in, 1: clears `underflow` (priority over set).
- `err_cnt`, out, 8: saturating count of frame sync errors.

## Operation
- **FIFO** (DW+1 bits: `{sof, dat}`):
  - `pix_rdy = !full && en`.
  - Push on `pix_vld && pix_rdy` every clk, independent of `clk_en`.
  - Pop only on `clk_en`.
  - No fall-through: a word pushed in cycle N is poppable from N+1.
  - Push and pop in the same cycle are both honoured; level is unchanged.
- **States** (one-hot or encoded, in package):
  - WAIT_SOF:
    - On `clk_en`, pop and discard head words while head `sof==0`.
    - If the head has `sof==1`, go to WAIT_FRAME without popping.
  - WAIT_FRAME:
    - Hold the FIFO.
    - On `clk_en && a_start`: pop head, output it, go to RUN.
  - RUN, on each `clk_en` with `active`:
    - FIFO empty: output `UNDER_COLOR`, set `underflow`, no pop, stay in RUN.
    - `a_start` and head `sof==1`: pop, output the word (normal frame boundary).
    - `a_start` and head `sof==0`: sync error. Output `UNDER_COLOR`, set `underflow`, increment `err_cnt`, go to WAIT_SOF.
    - `!a_start` and head `sof==1` (early sof): sync error. Output `UNDER_COLOR`, do not pop, increment `err_cnt`, go to WAIT_FRAME.
    - Otherwise: pop and output.
- **Outside active** (all states): `vid_dat` is 0, no pop.
- **Frame timing:**
  - In WAIT_SOF and WAIT_FRAME, active pixels output `UNDER_COLOR`.
  - `underflow` is not set in these states: resync is expected.
- **Disable:** `en` low flushes the FIFO pointers, forces WAIT_SOF and drives `vid_de=0`. `vid_hs`/`vid_vs` still follow their inputs.
- **Counters:** `err_cnt` saturates at 255 and is cleared only by reset or `clr`.

## Timing
- All outputs are registered and update only on `clk_en` (except `pix_rdy`, `underflow`, `err_cnt`).
- Latency: inputs sampled at `clk_en` edge N appear on the `vid_*` outputs after edge N; this is 1 `clk_en` tick behind the sync gen, and all four outputs stay aligned.
- `vid_de = active && en`, delayed 1 tick.
- Reset values:
  - `vid_dat` = 0, `vid_de` = 0, `vid_hs` = 0, `vid_vs` = 0.
  - `underflow` = 0, `err_cnt` = 0.
  - `pix_rdy` = 0 during reset.
  - State is WAIT_SOF and the FIFO is empty.
- Reset mid-frame: immediate return to reset state. After release, resync waits for the next `sof` and `a_start`.
- `clr` and an error in the same cycle: `underflow` ends at 0, `err_cnt` ends at 0.

## Structure
- Package `video_pkg`: state encoding constants, default `UNDER_COLOR`.
- Sub-module `video_fifo_sync` (`#(DW, AW)`): synchronous FIFO with pointer flush, `full`/`empty`, AW+1-bit pointers.
- Top holds the FSM, output registers and status.

## Test plan
- **Normal frames:** reset, prefill 16 words with `sof` on the first. Run 2 frames of a 4x2 active mode with a matching stream → `vid_dat` equals the stream in order, `vid_de` is aligned 1 tick after `active`, `underflow=0`, `err_cnt=0`.
- **Leading garbage:** 3 words with `sof=0`, then the frame → the 3 words are discarded, the first active pixel is the `sof` word.
- **Underflow:** stall `pix_vld` after 5 pixels of a frame → remaining active pixels are 24'hff00ff, `underflow=1`, and it stays set until a `clr` pulse, after which it reads 0.
- **Misalignment:** `sof` arrives 2 pixels early → early-sof error, `err_cnt=1`, and the next frame outputs correctly.
- **FIFO full:** no pops for 20 cycles → `pix_rdy` drops after 16 pushes, no data loss.
- **Reset during RUN:** assert `rst_n` low mid-line → all outputs 0 asynchronously and `pix_rdy=0`; after release, resync happens on the next frame.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg
// Shared definitions for the pixel output stage: resync state encoding,
// the default colour driven on underflow / sync errors, and the error
// counter ceiling.
package video_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_SOF   = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_RUN        = 2'd2
  } vid_state_e;

  localparam logic [23:0] UNDER_COLOR_DEFAULT = 24'hff00ff;
  localparam logic [7:0]  ERR_CNT_MAX         = 8'hff;

endpackage

// File: rtl/video_fifo_sync.sv
// video_fifo_sync
// Synchronous FIFO, depth 2**AW, with a pointer flush.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           returns both pointers to zero (FIFO empty)
//   push, wr_dat    write a word (ignored when full)
//   pop             advance the read pointer (ignored when empty)
//   rd_dat          current head word (valid when !empty)
//   full, empty     occupancy flags
module video_fifo_sync #(
  parameter int DW = 25,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wr_dat,
  input  logic          pop,
  output logic [DW-1:0] rd_dat,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  // The head is read straight from the array; a word written at an edge is
  // only visible after that edge, so there is no fall-through.
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/video_pixel_out.sv
// video_pixel_out
// Final video output stage behind video_sync_gen. Buffers the pixel stream
// in a prefetch FIFO, locks it to the sync generator's frame start, and
// drives the registered DE/HS/VS/RGB bus one clk_en tick behind the sync
// inputs. Underflow and frame misalignment are flagged and recovered from
// at the next frame start.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   clk_en                     pixel clock enable
//   en                         block enable (low: flush, resync, blank DE)
//   active, blank, a_start     sync generator timing
//   h_sync, v_sync             sync generator syncs (polarity applied)
//   pix_dat, pix_sof, pix_vld  pixel stream in
//   pix_rdy                    pixel stream ready
//   vid_dat, vid_de            output pixel and data enable
//   vid_hs, vid_vs             output syncs
//   underflow                  sticky underflow / sync error flag
//   clr                        clears underflow and err_cnt
//   err_cnt                    saturating frame sync error count
module video_pixel_out
  import video_pkg::*;
#(
  parameter int          DW          = 24,
  parameter int          AW          = 4,
  parameter logic [DW-1:0] UNDER_COLOR = DW'(UNDER_COLOR_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          en,
  input  logic          active,
  input  logic          blank,
  input  logic          a_start,
  input  logic          h_sync,
  input  logic          v_sync,
  input  logic [DW-1:0] pix_dat,
  input  logic          pix_sof,
  input  logic          pix_vld,
  output logic          pix_rdy,
  output logic [DW-1:0] vid_dat,
  output logic          vid_de,
  output logic          vid_hs,
  output logic          vid_vs,
  output logic          underflow,
  input  logic          clr,
  output logic [7:0]    err_cnt
);

  vid_state_e  state;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [DW:0] fifo_head;
  logic        head_sof;
  logic [DW-1:0] head_dat;
  logic        pix_tick;
  logic        uf_evt;
  logic        err_evt;

  // blank is the complement of active from the sync generator; only active
  // is needed to qualify pixel slots.
  logic unused_blank;
  assign unused_blank = blank;

  assign head_sof = fifo_head[DW];
  assign head_dat = fifo_head[DW-1:0];

  // Gated with rst_n so the stream sees "not ready" while held in reset.
  assign pix_rdy   = rst_n && en && !fifo_full;
  assign fifo_push = pix_vld && pix_rdy;

  // One active pixel slot of the sync generator.
  assign pix_tick = clk_en && en && active;

  // In RUN the stream is in step exactly when a_start and the head's sof
  // flag agree; any disagreement is a sync error.
  always_comb begin
    fifo_pop = 1'b0;
    uf_evt   = 1'b0;
    err_evt  = 1'b0;
    if (pix_tick) begin
      case (state)
        ST_WAIT_SOF:   fifo_pop = !fifo_empty && !head_sof;
        ST_WAIT_FRAME: fifo_pop = !fifo_empty && a_start;
        ST_RUN: begin
          if (fifo_empty) begin
            uf_evt = 1'b1;
          end else if (a_start == head_sof) begin
            fifo_pop = 1'b1;
          end else begin
            uf_evt  = 1'b1;
            err_evt = 1'b1;
          end
        end
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  video_fifo_sync #(
    .DW (DW+1),
    .AW (AW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (!en),
    .push   (fifo_push),
    .wr_dat ({pix_sof, pix_dat}),
    .pop    (fifo_pop),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Resync FSM, output registers and status. Video outputs move only on
  // clk_en; status reacts on the same edge as the event that caused it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT_SOF;
      vid_dat   <= '0;
      vid_de    <= 1'b0;
      vid_hs    <= 1'b0;
      vid_vs    <= 1'b0;
      underflow <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (!en) begin
        state <= ST_WAIT_SOF;
      end else if (clk_en) begin
        case (state)
          ST_WAIT_SOF:   if (!fifo_empty && head_sof) state <= ST_WAIT_FRAME;
          ST_WAIT_FRAME: if (fifo_pop) state <= ST_RUN;
          ST_RUN:        if (err_evt) state <= a_start ? ST_WAIT_SOF : ST_WAIT_FRAME;
          default:       state <= ST_WAIT_SOF;
        endcase
      end

      if (clk_en) begin
        vid_de <= active && en;
        vid_hs <= h_sync;
        vid_vs <= v_sync;
        if (!(active && en))
          vid_dat <= '0;
        else if (fifo_pop && state != ST_WAIT_SOF)
          vid_dat <= head_dat;
        else
          vid_dat <= UNDER_COLOR;
      end

      if (clr) begin
        underflow <= 1'b0;
        err_cnt   <= '0;
      end else begin
        if (uf_evt) underflow <= 1'b1;
        if (err_evt && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
